// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic blocks: controller state encoding
// and the default operand width.
package arith_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full_subtractor cell reused over WIDTH
// cycles, with a start/busy/done handshake and registered Diff/BorrowOut.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter  int WIDTH = ARITH_W,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_sh_reg;
    logic [WIDTH-1:0] diff_sh_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_out_reg;

    logic             load;
    logic             step;
    logic             finish;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Each new difference bit enters at the MSB, so after WIDTH steps the
    // first (LSB) result bit has walked down to bit 0.
    assign diff_sh_next = {cell_d, diff_sh_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            diff_sh_reg    <= '0;
            cnt_reg        <= '0;
            borrow_reg     <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
        end else if (load) begin
            a_sh_reg    <= A;
            b_sh_reg    <= B;
            diff_sh_reg <= '0;
            cnt_reg     <= '0;
            borrow_reg  <= 1'b0;
        end else if (step) begin
            a_sh_reg    <= a_sh_reg >> 1;
            b_sh_reg    <= b_sh_reg >> 1;
            diff_sh_reg <= diff_sh_next;
            cnt_reg     <= cnt_reg + CNT_W'(1);
            borrow_reg  <= cell_bout;
            // Visible results change only here, on the RUN->DONE edge.
            if (finish) begin
                diff_reg       <= diff_sh_next;
                borrow_out_reg <= cell_bout;
            end
        end
    end

    assign Diff      = diff_reg;
    assign BorrowOut = borrow_out_reg;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic
// reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .busy      (busy),
        .done      (done),
        .Diff      (diff),
        .BorrowOut (borrow_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    // Runs one operation from IDLE; reports result, edges-to-done (accept edge
    // counted as 1), busy cycles and whether done arrived in time.
    task automatic do_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input bit scramble,
                         output logic [W-1:0] d, output logic bo, output int lat,
                         output int busy_n, output bit ok);
        d = '0; bo = 1'b0; ok = 1'b0; lat = 0; busy_n = 0;
        @(negedge clk);
        a = opa; b = opb; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_n++;
            if (done) begin
                ok = 1'b1;
                d  = diff;
                bo = borrow_out;
                break;
            end
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, diff, borrow_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b Diff=%b BorrowOut=%b, required all 0",
                     busy, done, diff, borrow_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] d; logic bo; int lat, bn; bit ok;
        do_op(4'b0101, 4'b0011, 1'b0, d, bo, lat, bn, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: no done within bound"); end
        checks++;
        if (lat != W + 1) begin errors++; $display("FAIL basic_latency: got %0d edges, required %0d", lat, W + 1); end
        checks++;
        if (bn != W + 1) begin errors++; $display("FAIL basic_busy: busy %0d cycles, required %0d", bn, W + 1); end
        checks++;
        if (d !== 4'b0010 || bo !== 1'b0) begin
            errors++; $display("FAIL basic_result: Diff=%b Borrow=%b, required 0010 0", d, bo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [6] = '{4'b0011, 4'b0000, 4'b1001, 4'b1111, 4'b0000, 4'b1000};
        logic [W-1:0] vb [6] = '{4'b0101, 4'b0001, 4'b1001, 4'b0000, 4'b1111, 4'b0001};
        logic [W-1:0] d; logic bo; int lat, bn; bit ok;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 1'b0, d, bo, lat, bn, ok);
            checks++;
            if (!ok || d !== model_diff(va[i], vb[i]) || bo !== model_borrow(va[i], vb[i])) begin
                errors++;
                $display("FAIL vector A=%b B=%b: ok=%0d Diff=%b Borrow=%b, required %b %b",
                         va[i], vb[i], ok, d, bo, model_diff(va[i], vb[i]), model_borrow(va[i], vb[i]));
            end
        end
    endtask

    task automatic test_ignore_start();
        bit got = 1'b0;
        bit extra = 1'b0;
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a = 4'b0000; b = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || diff !== 4'b0010 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: got=%0d Diff=%b Borrow=%b, required 0010 0", got, diff, borrow_out);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL ignore_start_queued: extra operation observed, required none"); end
    endtask

    task automatic test_back_to_back();
        int done_cyc [3];
        int n = 0;
        int cyc = 0;
        bit unstable = 1'b0;
        logic [W-1:0] held;
        logic         held_bo;
        @(negedge clk);
        a = 4'b0011; b = 4'b0101; start = 1'b1;
        held = '0; held_bo = 1'b0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_cyc[n] = cyc;
                checks++;
                if (diff !== 4'b1110 || borrow_out !== 1'b1) begin
                    errors++; $display("FAIL b2b_result %0d: Diff=%b Borrow=%b, required 1110 1", n, diff, borrow_out);
                end
                held = diff; held_bo = borrow_out;
                n++;
            end else if (n > 0 && (diff !== held || borrow_out !== held_bo)) begin
                unstable = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL b2b_count: %0d dones, required 3", n);
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] != W + 2 || done_cyc[2] - done_cyc[1] != W + 2) begin
                errors++;
                $display("FAIL b2b_spacing: %0d and %0d cycles, required %0d", done_cyc[1] - done_cyc[0],
                         done_cyc[2] - done_cyc[1], W + 2);
            end
        end
        checks++;
        if (unstable) begin errors++; $display("FAIL b2b_hold: outputs changed between dones, required stable"); end
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] d; logic bo; int lat, bn; bit ok;
        bit spurious = 1'b0;
        do_op(4'b0000, 4'b1111, 1'b0, d, bo, lat, bn, ok);
        checks++;
        if (!ok || d !== 4'b0001 || bo !== 1'b1) begin
            errors++; $display("FAIL wrap_result: Diff=%b Borrow=%b, required 0001 1", d, bo);
        end
        @(negedge clk);
        a = 4'b1000; b = 4'b0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b Diff=%b Borrow=%b, required all 0",
                     busy, done, diff, borrow_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || diff !== '0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL abort_no_done: activity after reset release, required idle"); end
        do_op(4'b1000, 4'b0001, 1'b0, d, bo, lat, bn, ok);
        checks++;
        if (!ok || d !== 4'b0111 || bo !== 1'b0 || lat != W + 1) begin
            errors++; $display("FAIL abort_recover: Diff=%b Borrow=%b lat=%0d, required 0111 0 %0d", d, bo, lat, W + 1);
        end
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] d; logic bo; int lat, bn; bit ok;
        logic [W-1:0] sum;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(W'(i), W'(j), 1'b0, d, bo, lat, bn, ok);
                checks++;
                if (!ok || d !== model_diff(W'(i), W'(j)) || bo !== model_borrow(W'(i), W'(j))) begin
                    errors++;
                    $display("FAIL exhaustive A=%0d B=%0d: Diff=%0d Borrow=%b, required %0d %b", i, j, d, bo,
                             model_diff(W'(i), W'(j)), model_borrow(W'(i), W'(j)));
                end
                sum = d + W'(j);
                checks++;
                if (sum !== W'(i)) begin
                    errors++; $display("FAIL adder_xcheck A=%0d B=%0d: Diff+B=%0d, required %0d", i, j, sum, i);
                end
            end
        end
    endtask

    task automatic test_random_scramble();
        logic [W-1:0] d; logic bo; int lat, bn; bit ok;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, 1'b1, d, bo, lat, bn, ok);
            checks++;
            if (!ok || lat != W + 1 || d !== model_diff(ra, rb) || bo !== model_borrow(ra, rb)) begin
                errors++;
                $display("FAIL random A=%b B=%b: Diff=%b Borrow=%b lat=%0d, required %b %b %0d", ra, rb, d, bo, lat,
                         model_diff(ra, rb), model_borrow(ra, rb), W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();
        test_random_scramble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing Diff = A - B with a borrow-out flag.
- Multi-cycle complement to the team's combinational 4-bit adder; one full-subtractor cell is reused over WIDTH cycles.
- Sits in the arithmetic blocks area and uses a start/busy/done handshake so a controller can sequence operations.
- Diff + B (mod 2^WIDTH) must equal A, which gives a direct cross-check against the existing adder.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start.
- B  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; Diff/BorrowOut are fresh this cycle.
- Diff  output  WIDTH  registered result A - B mod 2^WIDTH.
- BorrowOut  output  1  registered borrow; 1 when A < B (unsigned).

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n=0: state=IDLE, busy=0, done=0, Diff=0, BorrowOut=0, shift registers=0, bit counter=0, internal borrow=0.
- States:
  - IDLE: busy=0. start=1 at edge k loads a_sh<=A, b_sh<=B, borrow<=0, cnt<=0, and moves to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each edge:
    - d = a_sh[0]^b_sh[0]^borrow
    - borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow)
    - d shifts into the MSB of the diff shift register; a_sh and b_sh shift right; cnt<=cnt+1
    - On the edge where cnt==WIDTH-1, Diff and BorrowOut load from the final shift value and final borrow, and state goes to DONE.
  - DONE: busy=1 and done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency and throughput:
  - start accepted at edge k gives done=1 in the cycle after edge k+WIDTH.
  - For WIDTH=4: done appears 5 edges after start.
  - Throughput is one result per WIDTH+2 cycles.
- Output holding:
  - Diff and BorrowOut change only on the RUN->DONE transition, never mid-operation.
  - They hold their value until the next completion.
- Boundary conditions:
  - start while busy (RUN or DONE) is ignored. No queueing; the in-flight operation is unaffected.
  - A and B changing after acceptance have no effect.
  - A==B gives Diff=0, BorrowOut=0.
  - A=0, B=2^WIDTH-1 gives Diff=1, BorrowOut=1.
  - Wrap-around is mod 2^WIDTH; there is no saturation.
  - start held high continuously gives back-to-back operations, one accept per IDLE visit.
  - rst_n low mid-RUN or in DONE aborts immediately: done is not pulsed and outputs are zero after release.
  - First accept is possible at the first edge with rst_n=1.
- No X on any output after reset.

Decomposition:
- Shared package arith_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - default operand width constant ARITH_W=4.
- Sub-module full_subtractor (combinational 1-bit):
  - inputs a, b, bin; outputs d, bout.
  - instantiated once in the datapath.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- Basic: reset, then A=0101, B=0011, start 1 cycle -> done after 5 edges, Diff=0010, BorrowOut=0, busy high 5 cycles.
- Negative result: A=0011, B=0101 -> Diff=1110, BorrowOut=1.
- Edge values:
  - A=0000, B=0001 -> Diff=1111, BorrowOut=1.
  - A=1001, B=1001 -> Diff=0000, BorrowOut=0.
  - A=1111, B=0000 -> Diff=1111, BorrowOut=0.
- Protocol:
  - start pulsed again 2 cycles after acceptance with A=0000 -> ignored; the first result is unchanged.
  - start held high -> consecutive dones exactly 6 cycles apart.
  - Diff and BorrowOut stable between dones.
- Reset mid-op: start A=1000, B=0001, drive rst_n=0 asynchronously between edges 2 and 3 -> outputs 0 immediately, no done pulse, a clean new operation afterwards.
- Exhaustive cross-check: all 256 A/B pairs (WIDTH=4) -> Diff == (A-B)&4'hF and BorrowOut == (A<B). Also Adder4Bit(Diff, B).Sum == A.
